// File: rtl/branch_rs_unit_pkg.sv
// Shared definitions for the branch reservation station: branch op codes,
// the "operand present" tag value and the op field width.
package branch_rs_unit_pkg;

    localparam int unsigned BR_OP_W  = 3;
    // A source tag of zero means the operand value is already held.
    localparam int unsigned TAG_FREE = 0;

    typedef enum logic [BR_OP_W-1:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } br_op_e;

endpackage

// File: rtl/branch_rs_unit_cmp.sv
// Combinational branch comparator: (op, a, b) -> taken.
// BLT/BGE compare signed, BLTU/BGEU unsigned; unknown op codes are not taken.
module branch_rs_unit_cmp
    import branch_rs_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [BR_OP_W-1:0] op_i,
    input  logic [DATA_W-1:0]  a_i,
    input  logic [DATA_W-1:0]  b_i,
    output logic               taken_o
);

    // Evaluate the branch condition selected by the op code.
    always_comb begin
        taken_o = 1'b0;
        case (op_i)
            BR_BEQ:  taken_o = (a_i == b_i);
            BR_BNE:  taken_o = (a_i != b_i);
            BR_BLT:  taken_o = ($signed(a_i) <  $signed(b_i));
            BR_BGE:  taken_o = ($signed(a_i) >= $signed(b_i));
            BR_BLTU: taken_o = (a_i <  b_i);
            BR_BGEU: taken_o = (a_i >= b_i);
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_rs_unit.sv
// Branch reservation station. Holds decoded conditional branches until both
// operands are known (snooping the CDBs), then issues the oldest ready entry
// through a registered valid/ready result port.
//
// Result handshake: res_valid/res_taken/res_offset/res_slot come straight from
// registers. While res_valid is high and res_ready is low they hold stable.
// A transfer happens on a rising edge where res_valid & res_ready; that edge
// frees the entry named by res_slot and may load the next result.
//
// Age bookkeeping: valid entries carry distinct ages 0..count-1, the largest
// being the oldest. Allocation inserts at age 0 and bumps everyone else; a free
// closes the gap by decrementing the entries older than the freed one.
module branch_rs_unit
    import branch_rs_unit_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4,
    parameter int ADDR_W  = 32,
    parameter int NUM_CDB = 2
) (
    input  logic                      exclk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      alloc_valid,
    output logic                      alloc_ready,
    input  logic [BR_OP_W-1:0]        alloc_op,
    input  logic [TAG_W-1:0]          alloc_tag1,
    input  logic [TAG_W-1:0]          alloc_tag2,
    input  logic [DATA_W-1:0]         alloc_data1,
    input  logic [DATA_W-1:0]         alloc_data2,
    input  logic [ADDR_W-1:0]         alloc_offset,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      res_taken,
    output logic [ADDR_W-1:0]         res_offset,
    output logic [$clog2(DEPTH)-1:0]  res_slot,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [TAG_W-1:0] TAG_NONE = TAG_W'(TAG_FREE);

    // Entry storage
    logic                valid_q  [DEPTH];
    logic                valid_d  [DEPTH];
    logic                issued_q [DEPTH];
    logic                issued_d [DEPTH];
    logic [BR_OP_W-1:0]  op_q     [DEPTH];
    logic [BR_OP_W-1:0]  op_d     [DEPTH];
    logic [TAG_W-1:0]    tag1_q   [DEPTH];
    logic [TAG_W-1:0]    tag1_d   [DEPTH];
    logic [TAG_W-1:0]    tag2_q   [DEPTH];
    logic [TAG_W-1:0]    tag2_d   [DEPTH];
    logic [DATA_W-1:0]   data1_q  [DEPTH];
    logic [DATA_W-1:0]   data1_d  [DEPTH];
    logic [DATA_W-1:0]   data2_q  [DEPTH];
    logic [DATA_W-1:0]   data2_d  [DEPTH];
    logic [ADDR_W-1:0]   offset_q [DEPTH];
    logic [ADDR_W-1:0]   offset_d [DEPTH];
    logic [IDX_W-1:0]    age_q    [DEPTH];
    logic [IDX_W-1:0]    age_d    [DEPTH];

    // Result register and occupancy
    logic                res_valid_q, res_valid_d;
    logic                res_taken_q, res_taken_d;
    logic [ADDR_W-1:0]   res_offset_q, res_offset_d;
    logic [IDX_W-1:0]    res_slot_q, res_slot_d;
    logic [CNT_W-1:0]    count_q, count_d;

    // Wake-up results per entry (operands after this cycle's CDB snoop)
    logic [TAG_W-1:0]    wk_tag1  [DEPTH];
    logic [TAG_W-1:0]    wk_tag2  [DEPTH];
    logic [DATA_W-1:0]   wk_data1 [DEPTH];
    logic [DATA_W-1:0]   wk_data2 [DEPTH];

    // Allocation operands after same-cycle CDB bypass
    logic [TAG_W-1:0]    al_tag1, al_tag2;
    logic [DATA_W-1:0]   al_data1, al_data2;

    logic [DEPTH-1:0]    ready;
    logic                any_ready;
    logic [IDX_W-1:0]    sel_idx;
    logic [IDX_W-1:0]    sel_age;
    logic [IDX_W-1:0]    alloc_idx;
    logic [IDX_W-1:0]    free_age;
    logic                alloc_fire;
    logic                free_fire;
    logic                issue_fire;
    logic                cmp_taken;
    logic [BR_OP_W-1:0]  sel_op;
    logic [DATA_W-1:0]   sel_a, sel_b;

    // Lowest-index CDB carrying a nonzero matching tag; returns {hit, data}.
    function automatic logic [DATA_W:0] cdb_snoop(
        input logic [TAG_W-1:0]          tag,
        input logic [NUM_CDB-1:0]        bus_v,
        input logic [NUM_CDB*TAG_W-1:0]  bus_tag,
        input logic [NUM_CDB*DATA_W-1:0] bus_data
    );
        logic [DATA_W:0] r;
        r = '0;
        for (int b = NUM_CDB - 1; b >= 0; b--) begin
            if (bus_v[b] && (tag != TAG_NONE) && (bus_tag[b*TAG_W +: TAG_W] == tag)) begin
                r = {1'b1, bus_data[b*DATA_W +: DATA_W]};
            end
        end
        return r;
    endfunction

    assign alloc_ready = (count_q < CNT_W'(DEPTH));
    assign alloc_fire  = alloc_valid & alloc_ready;
    assign free_fire   = res_valid_q & res_ready;
    assign free_age    = age_q[res_slot_q];

    assign res_valid  = res_valid_q;
    assign res_taken  = res_taken_q;
    assign res_offset = res_offset_q;
    assign res_slot   = res_slot_q;
    assign count      = count_q;

    // Operand wake-up: pending tags of valid entries capture matching CDB data.
    always_comb begin
        logic [DATA_W:0] hit1, hit2;
        for (int i = 0; i < DEPTH; i++) begin
            hit1        = cdb_snoop(tag1_q[i], cdb_valid, cdb_tag, cdb_data);
            hit2        = cdb_snoop(tag2_q[i], cdb_valid, cdb_tag, cdb_data);
            wk_tag1[i]  = tag1_q[i];
            wk_data1[i] = data1_q[i];
            wk_tag2[i]  = tag2_q[i];
            wk_data2[i] = data2_q[i];
            if (valid_q[i] && hit1[DATA_W]) begin
                wk_tag1[i]  = TAG_NONE;
                wk_data1[i] = hit1[DATA_W-1:0];
            end
            if (valid_q[i] && hit2[DATA_W]) begin
                wk_tag2[i]  = TAG_NONE;
                wk_data2[i] = hit2[DATA_W-1:0];
            end
        end
    end

    // Same-cycle bypass of CDB results into an incoming allocation.
    always_comb begin
        logic [DATA_W:0] hit1, hit2;
        hit1     = cdb_snoop(alloc_tag1, cdb_valid, cdb_tag, cdb_data);
        hit2     = cdb_snoop(alloc_tag2, cdb_valid, cdb_tag, cdb_data);
        al_tag1  = hit1[DATA_W] ? TAG_NONE : alloc_tag1;
        al_data1 = hit1[DATA_W] ? hit1[DATA_W-1:0] : alloc_data1;
        al_tag2  = hit2[DATA_W] ? TAG_NONE : alloc_tag2;
        al_data2 = hit2[DATA_W] ? hit2[DATA_W-1:0] : alloc_data2;
    end

    // Oldest-ready select: largest age among entries with both operands present.
    always_comb begin
        any_ready = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = valid_q[i] & ~issued_q[i] &
                       (tag1_q[i] == TAG_NONE) & (tag2_q[i] == TAG_NONE);
            if (ready[i] && (!any_ready || (age_q[i] > sel_age))) begin
                any_ready = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_age   = age_q[i];
            end
        end
    end

    assign issue_fire = any_ready & (~res_valid_q | res_ready);

    // Allocation slot: lowest-index entry that is currently invalid.
    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                alloc_idx = IDX_W'(i);
            end
        end
    end

    assign sel_op = op_q[sel_idx];
    assign sel_a  = data1_q[sel_idx];
    assign sel_b  = data2_q[sel_idx];

    branch_rs_unit_cmp #(
        .DATA_W (DATA_W)
    ) u_cmp (
        .op_i    (sel_op),
        .a_i     (sel_a),
        .b_i     (sel_b),
        .taken_o (cmp_taken)
    );

    // Entry next state: wake-up, issue mark, free, age maintenance, allocation.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid_d[i]  = valid_q[i];
            issued_d[i] = issued_q[i];
            op_d[i]     = op_q[i];
            tag1_d[i]   = wk_tag1[i];
            data1_d[i]  = wk_data1[i];
            tag2_d[i]   = wk_tag2[i];
            data2_d[i]  = wk_data2[i];
            offset_d[i] = offset_q[i];
            age_d[i]    = age_q[i];
            // Free decrement first, then the allocation increment.
            if (valid_q[i]) begin
                if (free_fire && (age_q[i] > free_age)) begin
                    age_d[i] = age_q[i] - 1'b1;
                end
                if (alloc_fire) begin
                    age_d[i] = age_d[i] + 1'b1;
                end
            end
            if (issue_fire && (sel_idx == IDX_W'(i))) begin
                issued_d[i] = 1'b1;
            end
            if (free_fire && (res_slot_q == IDX_W'(i))) begin
                valid_d[i]  = 1'b0;
                issued_d[i] = 1'b0;
            end
            if (alloc_fire && (alloc_idx == IDX_W'(i))) begin
                valid_d[i]  = 1'b1;
                issued_d[i] = 1'b0;
                op_d[i]     = alloc_op;
                tag1_d[i]   = al_tag1;
                data1_d[i]  = al_data1;
                tag2_d[i]   = al_tag2;
                data2_d[i]  = al_data2;
                offset_d[i] = alloc_offset;
                age_d[i]    = '0;
            end
        end
    end

    // Result register and occupancy next state.
    always_comb begin
        res_valid_d  = res_valid_q;
        res_taken_d  = res_taken_q;
        res_offset_d = res_offset_q;
        res_slot_d   = res_slot_q;
        if (free_fire) begin
            res_valid_d = 1'b0;
        end
        if (issue_fire) begin
            res_valid_d  = 1'b1;
            res_taken_d  = cmp_taken;
            res_offset_d = offset_q[sel_idx];
            res_slot_d   = sel_idx;
        end
        count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(free_fire);
    end

    // State register: async reset, flush clears control state and the result.
    always_ff @(posedge exclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]  <= 1'b0;
                issued_q[i] <= 1'b0;
                op_q[i]     <= '0;
                tag1_q[i]   <= '0;
                data1_q[i]  <= '0;
                tag2_q[i]   <= '0;
                data2_q[i]  <= '0;
                offset_q[i] <= '0;
                age_q[i]    <= '0;
            end
            res_valid_q  <= 1'b0;
            res_taken_q  <= 1'b0;
            res_offset_q <= '0;
            res_slot_q   <= '0;
            count_q      <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]     <= op_d[i];
                tag1_q[i]   <= tag1_d[i];
                data1_q[i]  <= data1_d[i];
                tag2_q[i]   <= tag2_d[i];
                data2_q[i]  <= data2_d[i];
                offset_q[i] <= offset_d[i];
                age_q[i]    <= age_d[i];
            end
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    valid_q[i]  <= 1'b0;
                    issued_q[i] <= 1'b0;
                end
                res_valid_q  <= 1'b0;
                res_taken_q  <= 1'b0;
                res_offset_q <= '0;
                res_slot_q   <= '0;
                count_q      <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    valid_q[i]  <= valid_d[i];
                    issued_q[i] <= issued_d[i];
                end
                res_valid_q  <= res_valid_d;
                res_taken_q  <= res_taken_d;
                res_offset_q <= res_offset_d;
                res_slot_q   <= res_slot_d;
                count_q      <= count_d;
            end
        end
    end

endmodule
